lane_dly_tap_seq: RTL and testbench
===================================

LANE_DLY_TAP_SEQ -- requirements
Module: lane_dly_tap_seq

Interface
REQ-001 Parameter PRE_CYC, default 2: HS_IO_CLK_PAUSE lead cycles before the first delay-line strobe; legal range >= 1.
REQ-002 Parameter GAP_CYC, default 3: idle cycles after each strobe; legal range >= 1.
REQ-003 Parameter POST_CYC, default 2: pause hold cycles after the last gap; legal range >= 1.
REQ-004 Parameter TAP_W, default 8: width of the tap count fields.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 FAB_CLK  in  1  sole clock, all logic rising-edge.
REQ-007 RESET_N  in  1  asynchronous active-low reset.
REQ-008 REQ_VALID  in  1  request strobe.
REQ-009 REQ_READY  out  1  high only in IDLE.
REQ-010 REQ_OP  in  2  operation code: 00 move, 01 load; 1x reserved.
REQ-011 REQ_SEL  in  1  delay line select: 0 RX, 1 TX.
REQ-012 REQ_DIR  in  1  move direction, passed through to DELAY_LINE_DIRECTION.
REQ-013 REQ_TAPS  in  TAP_W  number of move strobes.
REQ-014 DONE  out  1  one-cycle completion pulse.
REQ-015 ERR  out  1  error flag, valid only while DONE=1.
REQ-016 TAPS_DONE  out  TAP_W  strobes issued for the request, valid while DONE=1.
REQ-017 DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DELAY_LINE_MOVE, HS_IO_CLK_PAUSE  out  1 each  lane controller controls.
REQ-018 RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE  in  1 each  lane controller status.

Function
REQ-019 FSM states: IDLE, PRE, STROBE, GAP, POST, RESP.
REQ-020 Accept: REQ_VALID=1 and REQ_READY=1 in cycle T; REQ_SEL, REQ_DIR, REQ_OP and REQ_TAPS are latched at T.
REQ-021 REQ_VALID while busy is ignored; requests are never queued.
REQ-022 PRE lasts PRE_CYC cycles (T+1..T+PRE_CYC). DELAY_LINE_SEL and DELAY_LINE_DIRECTION are driven from latched values PRE through POST and held stable.
REQ-023 STROBE, one cycle: DELAY_LINE_MOVE=1 for op move, DELAY_LINE_LOAD=1 for op load. Never both; only one-cycle pulses.
REQ-024 Strobe count: each STROBE increments the tap counter. GAP_CYC cycles of GAP follow every STROBE.
REQ-025 Move with N>0 issues N strobes; strobe k occurs at T+PRE_CYC+1+(k-1)(GAP_CYC+1).
REQ-026 Load issues exactly 1 strobe; REQ_TAPS is ignored.
REQ-027 Move with N=0 goes PRE -> POST with no strobe; TAPS_DONE=0, ERR=0.
REQ-028 Out-of-range check: the selected line's out-of-range input is sampled in the last GAP cycle; if high, remaining strobes are skipped, the FSM goes to POST, and ERR=1 at DONE. TAPS_DONE includes the offending strobe.
REQ-029 POST lasts POST_CYC cycles, then RESP.
REQ-030 RESP lasts one cycle: DONE=1, then IDLE.
REQ-031 HS_IO_CLK_PAUSE is high exactly from the first PRE cycle through the last POST cycle.
REQ-032 Latency: DONE at T+PRE_CYC+N(GAP_CYC+1)+POST_CYC+1, with N=1 for load; defaults, N=4: T+21.
REQ-033 Reserved op 1x: go directly IDLE -> RESP, DONE at T+1 with ERR=1 and TAPS_DONE=0; no pause, no strobe.
REQ-034 Tap counter is TAP_W bits; N=2^TAP_W-1 completes without wrap.
REQ-035 Simultaneous last-strobe completion and out-of-range: ERR=1 and TAPS_DONE=N.

Reset
REQ-036 RESET_N low asynchronously forces IDLE and clears all registers; every output is 0 except REQ_READY=1 after release.
REQ-037 Reset mid-operation drops HS_IO_CLK_PAUSE immediately, with no DONE; the first accept is allowed in the first cycle after release.

Structure
REQ-038 Package lane_dly_pkg holds the state enum, op codes (OP_MOVE, OP_LOAD) and SEL_RX/SEL_TX constants.
REQ-039 One sub-module, lane_dly_wait_cnt: loadable down-counter with a zero flag, shared by PRE, GAP and POST.

Verification
REQ-040 Move RX, N=4, DIR=1, defaults: MOVE pulses at T+3,7,11,15; PAUSE high T+1..T+20; DONE at T+21, ERR=0, TAPS_DONE=4.
REQ-041 Load TX: LOAD pulse at T+3, SEL=1 held T+1..T+8, DONE at T+9, MOVE never asserted.
REQ-042 Move RX, N=10, RX_OUT_OF_RANGE raised at T+8: strobes at T+3,7 only; DONE at T+13 with ERR=1, TAPS_DONE=2. TX_OUT_OF_RANGE toggling throughout has no effect.
REQ-043 N=0 gives DONE at T+5, PAUSE T+1..T+4. Reserved op 2'b10 gives DONE+ERR at T+1, PAUSE never high.
REQ-044 RESET_N low at T+9 mid-move: all outputs 0 within the same cycle, no DONE; a new request accepted at the first cycle after release completes normally.
REQ-045 REQ_VALID held high continuously: back-to-back requests are accepted only in the cycle after each DONE, and READY=0 throughout each operation.

Source files
------------

// File: rtl/lane_dly_pkg.sv
// Shared constants for the lane delay-line tap sequencer: state encoding,
// operation codes and delay-line select values.
package lane_dly_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_PRE    = 3'd1;
   localparam state_t ST_STROBE = 3'd2;
   localparam state_t ST_GAP    = 3'd3;
   localparam state_t ST_POST   = 3'd4;
   localparam state_t ST_RESP   = 3'd5;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;

   localparam logic SEL_RX = 1'b0;
   localparam logic SEL_TX = 1'b1;

   localparam int WAIT_W = 16;

   // Any op code with the upper bit set is reserved and answered with an error.
   function automatic logic op_reserved(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/lane_dly_tap_seq_if.sv
// Request/response bus between a tap-sequence requester and the sequencer.
interface lane_dly_tap_seq_if #(
   parameter int TAP_W = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic             req_sel;
   logic             req_dir;
   logic [TAP_W-1:0] req_taps;
   logic             done;
   logic             err;
   logic [TAP_W-1:0] taps_done;

   modport master (
      output req_valid, req_op, req_sel, req_dir, req_taps,
      input  req_ready, done, err, taps_done
   );

   modport slave (
      input  req_valid, req_op, req_sel, req_dir, req_taps,
      output req_ready, done, err, taps_done
   );
endinterface

// File: rtl/lane_dly_wait_cnt.sv
// Loadable down-counter with a zero flag; times the PRE, GAP and POST phases.
module lane_dly_wait_cnt
   import lane_dly_pkg::*;
#(
   parameter int W = WAIT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Count down to zero and park there until reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != '0) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == '0);

endmodule

// File: rtl/lane_dly_tap_seq.sv
// Delay-line tap sequencer: pauses the HS IO clock, issues move/load strobes
// with fixed spacing, stops early on out-of-range and reports completion.
module lane_dly_tap_seq
   import lane_dly_pkg::*;
#(
   parameter int PRE_CYC  = 2,
   parameter int GAP_CYC  = 3,
   parameter int POST_CYC = 2,
   parameter int TAP_W    = 8
) (
   input  logic               fab_clk,
   input  logic               reset_n,
   lane_dly_tap_seq_if.slave  bus,
   output logic               delay_line_sel,
   output logic               delay_line_direction,
   output logic               delay_line_load,
   output logic               delay_line_move,
   output logic               hs_io_clk_pause,
   input  logic               rx_delay_line_out_of_range,
   input  logic               tx_delay_line_out_of_range
);

   // Phase lengths are loaded as length-1 so the zero flag marks the last cycle.
   localparam logic [WAIT_W-1:0] PRE_LD  = WAIT_W'(PRE_CYC - 1);
   localparam logic [WAIT_W-1:0] GAP_LD  = WAIT_W'(GAP_CYC - 1);
   localparam logic [WAIT_W-1:0] POST_LD = WAIT_W'(POST_CYC - 1);

   state_t             state_r, state_nxt_s;
   logic [1:0]         op_r, op_nxt_s;
   logic               sel_r, sel_nxt_s;
   logic               dir_r, dir_nxt_s;
   logic [TAP_W-1:0]   taps_r, taps_nxt_s;
   logic [TAP_W-1:0]   cnt_r, cnt_nxt_s;
   logic               err_r, err_nxt_s;
   logic               wait_ld_s;
   logic [WAIT_W-1:0]  wait_val_s;
   logic               wait_zero_s;
   logic               oor_s;
   logic               last_tap_s;
   logic               busy_nxt_s;

   logic               ready_r, done_r, err_out_r;
   logic [TAP_W-1:0]   taps_done_r;
   logic               dl_sel_r, dl_dir_r, dl_load_r, dl_move_r, pause_r;

   lane_dly_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
      .clk      (fab_clk),
      .rst_n    (reset_n),
      .load     (wait_ld_s),
      .load_val (wait_val_s),
      .zero     (wait_zero_s)
   );

   assign oor_s      = (sel_r == SEL_TX) ? tx_delay_line_out_of_range
                                         : rx_delay_line_out_of_range;
   assign last_tap_s = (op_r == OP_LOAD) || (cnt_r == taps_r);
   assign busy_nxt_s = (state_nxt_s == ST_PRE)  || (state_nxt_s == ST_STROBE) ||
                       (state_nxt_s == ST_GAP)  || (state_nxt_s == ST_POST);

   // Next-state, request capture, tap counting and phase timer control.
   always_comb begin
      state_nxt_s = state_r;
      op_nxt_s    = op_r;
      sel_nxt_s   = sel_r;
      dir_nxt_s   = dir_r;
      taps_nxt_s  = taps_r;
      cnt_nxt_s   = cnt_r;
      err_nxt_s   = err_r;
      wait_ld_s   = 1'b0;
      wait_val_s  = '0;
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_nxt_s   = bus.req_op;
               sel_nxt_s  = bus.req_sel;
               dir_nxt_s  = bus.req_dir;
               taps_nxt_s = bus.req_taps;
               cnt_nxt_s  = '0;
               if (op_reserved(bus.req_op)) begin
                  err_nxt_s   = 1'b1;
                  state_nxt_s = ST_RESP;
               end else begin
                  err_nxt_s   = 1'b0;
                  state_nxt_s = ST_PRE;
                  wait_ld_s   = 1'b1;
                  wait_val_s  = PRE_LD;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (!wait_zero_s) begin
               state_nxt_s = ST_PRE;
            end else if ((op_r == OP_LOAD) || (taps_r != '0)) begin
               state_nxt_s = ST_STROBE;
            end else begin
               state_nxt_s = ST_POST;
               wait_ld_s   = 1'b1;
               wait_val_s  = POST_LD;
            end
         end
         ST_STROBE: begin
            cnt_nxt_s   = cnt_r + TAP_W'(1);
            state_nxt_s = ST_GAP;
            wait_ld_s   = 1'b1;
            wait_val_s  = GAP_LD;
         end
         ST_GAP: begin
            // Out-of-range wins over normal completion so the error is reported.
            if (!wait_zero_s) begin
               state_nxt_s = ST_GAP;
            end else if (oor_s || last_tap_s) begin
               err_nxt_s   = err_r | oor_s;
               state_nxt_s = ST_POST;
               wait_ld_s   = 1'b1;
               wait_val_s  = POST_LD;
            end else begin
               state_nxt_s = ST_STROBE;
            end
         end
         ST_POST: begin
            if (wait_zero_s) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_POST;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and latched request.
   always_ff @(posedge fab_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         op_r    <= 2'b00;
         sel_r   <= 1'b0;
         dir_r   <= 1'b0;
         taps_r  <= '0;
         cnt_r   <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         op_r    <= op_nxt_s;
         sel_r   <= sel_nxt_s;
         dir_r   <= dir_nxt_s;
         taps_r  <= taps_nxt_s;
         cnt_r   <= cnt_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // Outputs registered from the next state so they line up with the state itself.
   always_ff @(posedge fab_clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_r     <= 1'b1;
         done_r      <= 1'b0;
         err_out_r   <= 1'b0;
         taps_done_r <= '0;
         dl_sel_r    <= 1'b0;
         dl_dir_r    <= 1'b0;
         dl_load_r   <= 1'b0;
         dl_move_r   <= 1'b0;
         pause_r     <= 1'b0;
      end else begin
         ready_r     <= (state_nxt_s == ST_IDLE);
         done_r      <= (state_nxt_s == ST_RESP);
         err_out_r   <= (state_nxt_s == ST_RESP) && err_nxt_s;
         taps_done_r <= (state_nxt_s == ST_RESP) ? cnt_nxt_s : '0;
         dl_sel_r    <= busy_nxt_s && sel_nxt_s;
         dl_dir_r    <= busy_nxt_s && dir_nxt_s;
         dl_load_r   <= (state_nxt_s == ST_STROBE) && (op_nxt_s == OP_LOAD);
         dl_move_r   <= (state_nxt_s == ST_STROBE) && (op_nxt_s == OP_MOVE);
         pause_r     <= busy_nxt_s;
      end
   end

   assign bus.req_ready         = ready_r;
   assign bus.done              = done_r;
   assign bus.err               = err_out_r;
   assign bus.taps_done         = taps_done_r;
   assign delay_line_sel        = dl_sel_r;
   assign delay_line_direction  = dl_dir_r;
   assign delay_line_load       = dl_load_r;
   assign delay_line_move       = dl_move_r;
   assign hs_io_clk_pause       = pause_r;

endmodule

// File: tb/tb_lane_dly_tap_seq.sv
// Bench for lane_dly_tap_seq: timeline model compared every cycle, plus
// literal expectations for the documented scenarios.
module tb_lane_dly_tap_seq;
   import lane_dly_pkg::*;

   localparam int PRE  = 2;
   localparam int GAP  = 3;
   localparam int POST = 2;
   localparam int TW   = 8;

   logic fab_clk = 1'b0;
   logic reset_n = 1'b1;
   logic dl_sel, dl_dir, dl_load, dl_move, pause;
   logic rx_oor = 1'b0;
   logic tx_oor = 1'b0;

   lane_dly_tap_seq_if #(.TAP_W(TW)) bus ();

   lane_dly_tap_seq #(.PRE_CYC(PRE), .GAP_CYC(GAP), .POST_CYC(POST), .TAP_W(TW)) dut (
      .fab_clk                    (fab_clk),
      .reset_n                    (reset_n),
      .bus                        (bus),
      .delay_line_sel             (dl_sel),
      .delay_line_direction       (dl_dir),
      .delay_line_load            (dl_load),
      .delay_line_move            (dl_move),
      .hs_io_clk_pause            (pause),
      .rx_delay_line_out_of_range (rx_oor),
      .tx_delay_line_out_of_range (tx_oor)
   );

   always #5 fab_clk = ~fab_clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endfunction

   // Timeline model: cycle offsets since accept, strobe times by arithmetic.
   int         cyc = 0;
   bit         m_busy = 1'b0;
   int         m_k, m_issued, m_neff, m_end_k, m_last_s;
   bit         m_stopped, m_err, m_res, m_sel, m_dir;
   logic [1:0] m_op;
   int         m_strobe_q[$];
   int         acc_q[$];
   int         m_last_taps = -1;
   bit         m_last_err;
   bit         e_ready, e_done, e_err, e_sel, e_dir, e_load, e_move, e_pause;
   logic [7:0] e_taps;

   always @(posedge fab_clk) begin
      cyc = cyc + 1;
      if (!reset_n) begin
         m_busy = 1'b0;
      end else if (m_busy && e_done) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         if (!m_res && !m_stopped && m_issued > 0 && m_k == m_last_s + GAP) begin
            if ((m_sel ? tx_oor : rx_oor) == 1'b1) begin
               m_stopped = 1'b1; m_err = 1'b1; m_end_k = m_k;
            end else if (m_issued == m_neff) begin
               m_stopped = 1'b1; m_end_k = m_k;
            end
         end
      end else if (bus.req_valid) begin
         m_busy    = 1'b1;
         m_k       = 0;
         m_op      = bus.req_op;
         m_sel     = bus.req_sel;
         m_dir     = bus.req_dir;
         m_res     = bus.req_op[1];
         m_neff    = (bus.req_op == OP_LOAD) ? 1 : int'(bus.req_taps);
         m_issued  = 0;
         m_err     = m_res;
         m_stopped = (m_neff == 0) && !m_res;
         m_end_k   = PRE;
         m_strobe_q.delete();
         acc_q.push_back(cyc);
      end
      if (m_busy) m_k = m_k + 1;
      e_ready = !m_busy;
      e_done = 1'b0; e_err = 1'b0; e_taps = 8'd0;
      e_sel = 1'b0; e_dir = 1'b0; e_load = 1'b0; e_move = 1'b0; e_pause = 1'b0;
      if (m_busy) begin
         if (m_res) begin
            e_done = (m_k == 1);
         end else begin
            if (!m_stopped && m_k == PRE + 1 + m_issued * (GAP + 1)) begin
               e_move = (m_op == OP_MOVE);
               e_load = (m_op == OP_LOAD);
               m_issued = m_issued + 1;
               m_last_s = m_k;
               m_strobe_q.push_back(m_k);
            end
            e_pause = !m_stopped || (m_k <= m_end_k + POST);
            e_done  = m_stopped && (m_k == m_end_k + POST + 1);
            e_sel   = e_pause && m_sel;
            e_dir   = e_pause && m_dir;
         end
         if (e_done) begin
            e_err       = m_err;
            e_taps      = 8'(m_issued);
            m_last_taps = m_issued;
            m_last_err  = m_err;
         end
      end
   end

   logic [15:0] dv, ev;

   // Every-cycle comparison of all outputs against the model.
   always @(negedge fab_clk) begin
      dv = {bus.req_ready, bus.done, bus.err, bus.taps_done, dl_sel, dl_dir, dl_load, dl_move, pause};
      ev = {e_ready, e_done, e_err, e_taps, e_sel, e_dir, e_load, e_move, e_pause};
      if (!reset_n) begin
         ev = 16'h0000;
         dv[15] = 1'b0;
      end
      checks = checks + 1;
      if (dv !== ev) begin
         errors = errors + 1;
         $display("FAIL outputs cyc=%0d actual=%h expected=%h", cyc, dv, ev);
      end
   end

   task automatic run_req(input string name, input bit presync, input logic [1:0] op,
                          input logic sel, input logic dir, input logic [7:0] taps,
                          input int oor_at, input bit tog,
                          input int exp_done, input int exp_taps, input int exp_err);
      int i;
      if (presync) begin
         @(posedge fab_clk); #2;
      end
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_sel = sel;
      bus.req_dir = dir; bus.req_taps = taps;
      @(posedge fab_clk); #2;
      // Scramble the request fields to show they were latched at accept.
      bus.req_valid = 1'b0; bus.req_op = 2'b10; bus.req_sel = ~sel;
      bus.req_dir = ~dir; bus.req_taps = ~taps;
      i = 1;
      while (i < 2000) begin
         if (oor_at > 0 && i >= oor_at) begin
            if (sel) tx_oor = 1'b1; else rx_oor = 1'b1;
         end
         if (tog) begin
            if (sel) rx_oor = ~rx_oor; else tx_oor = ~tx_oor;
         end
         if (e_done) break;
         @(posedge fab_clk); #2;
         i = i + 1;
      end
      chk({name, "_done_cycle"}, i, exp_done);
      chk({name, "_taps_done"}, m_last_taps, exp_taps);
      chk({name, "_err"}, int'(m_last_err), exp_err);
      rx_oor = 1'b0;
      tx_oor = 1'b0;
   endtask

   initial begin
      int i;
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_sel = 1'b0;
      bus.req_dir = 1'b0; bus.req_taps = 8'd0;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge fab_clk);
      #2 reset_n = 1'b1;
      @(negedge fab_clk);
      chk("reset_ready", int'(bus.req_ready), 1);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_pause", int'(pause), 0);

      run_req("move4", 1'b1, OP_MOVE, SEL_RX, 1'b1, 8'd4, 0, 1'b0, 21, 4, 0);
      chk("move4_strobes", m_strobe_q.size(), 4);
      if (m_strobe_q.size() == 4) begin
         chk("move4_s1", m_strobe_q[0], 3);
         chk("move4_s2", m_strobe_q[1], 7);
         chk("move4_s3", m_strobe_q[2], 11);
         chk("move4_s4", m_strobe_q[3], 15);
      end
      run_req("load_tx", 1'b1, OP_LOAD, SEL_TX, 1'b0, 8'd9, 0, 1'b0, 9, 1, 0);
      chk("load_strobe_at", (m_strobe_q.size() == 1) ? m_strobe_q[0] : -1, 3);
      run_req("oor_rx", 1'b1, OP_MOVE, SEL_RX, 1'b0, 8'd10, 8, 1'b1, 13, 2, 1);
      run_req("move0", 1'b1, OP_MOVE, SEL_RX, 1'b1, 8'd0, 0, 1'b0, 5, 0, 0);
      run_req("rsv10", 1'b1, 2'b10, SEL_TX, 1'b1, 8'd3, 0, 1'b0, 1, 0, 1);
      run_req("rsv11", 1'b1, 2'b11, SEL_RX, 1'b0, 8'd7, 0, 1'b0, 1, 0, 1);
      run_req("oor_last", 1'b1, OP_MOVE, SEL_RX, 1'b1, 8'd2, 10, 1'b0, 13, 2, 1);
      run_req("oor_tx", 1'b1, OP_MOVE, SEL_TX, 1'b1, 8'd3, 4, 1'b1, 9, 1, 1);
      run_req("move255", 1'b1, OP_MOVE, SEL_TX, 1'b0, 8'd255, 0, 1'b0, 1025, 255, 0);

      // Reset in the middle of a move, then accept immediately after release.
      @(posedge fab_clk); #2;
      bus.req_valid = 1'b1; bus.req_op = OP_MOVE; bus.req_sel = SEL_RX;
      bus.req_dir = 1'b1; bus.req_taps = 8'd4;
      @(posedge fab_clk); #2;
      bus.req_valid = 1'b0;
      repeat (8) @(posedge fab_clk);
      #2;
      chk("pre_reset_pause", int'(pause), 1);
      reset_n = 1'b0;
      #1;
      chk("rst_pause", int'(pause), 0);
      chk("rst_sel_dir", int'({dl_sel, dl_dir}), 0);
      chk("rst_done", int'(bus.done), 0);
      repeat (2) @(posedge fab_clk);
      #2 reset_n = 1'b1;
      run_req("after_reset", 1'b0, OP_MOVE, SEL_TX, 1'b0, 8'd1, 0, 1'b0, 9, 1, 0);

      // Valid held high: each new accept lands the cycle after DONE.
      acc_q.delete();
      @(posedge fab_clk); #2;
      bus.req_valid = 1'b1; bus.req_op = OP_MOVE; bus.req_sel = SEL_TX;
      bus.req_dir = 1'b0; bus.req_taps = 8'd1;
      repeat (30) @(posedge fab_clk);
      #2 bus.req_valid = 1'b0;
      i = 0;
      while (m_busy && i < 100) begin
         @(posedge fab_clk);
         i = i + 1;
      end
      #2;
      chk("b2b_idle", int'(m_busy), 0);
      chk("b2b_accepts", acc_q.size(), 3);
      if (acc_q.size() >= 3) begin
         chk("b2b_gap1", acc_q[1] - acc_q[0], 10);
         chk("b2b_gap2", acc_q[2] - acc_q[1], 10);
      end

      repeat (3) @(posedge fab_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
